// File: rtl/front_pkg.sv
// Shared front-end package.
// Holds the enable/valid encodings and the default instruction/PC widths
// used by the fetch-to-decode instruction queue.
package front_pkg;
   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;
   localparam logic VALID   = 1'b1;
   localparam logic INVALID = 1'b0;

   localparam int DEF_INST_W = 32;
   localparam int DEF_ADDR_W = 32;
endpackage

// File: rtl/inst_queue_dual_if.sv
// Fetch/decode bus for the dual-issue instruction queue.
// Ports (slave = queue side):
//   in : rdy, stall, clear, instEnO/T, instO/T, PCO/T
//   out: ifStall, occupancy, DecEnO/T, DecInstO/T, DecPCO/T
// The master modport is the mirror image, used by the environment.
interface inst_queue_dual_if
   import front_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int INST_W = DEF_INST_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              rdy;
   logic              stall;
   logic              clear;
   logic              instEnO;
   logic              instEnT;
   logic [INST_W-1:0] instO;
   logic [INST_W-1:0] instT;
   logic [ADDR_W-1:0] PCO;
   logic [ADDR_W-1:0] PCT;
   logic              ifStall;
   logic [CNT_W-1:0]  occupancy;
   logic              DecEnO;
   logic              DecEnT;
   logic [INST_W-1:0] DecInstO;
   logic [INST_W-1:0] DecInstT;
   logic [ADDR_W-1:0] DecPCO;
   logic [ADDR_W-1:0] DecPCT;

   modport slave (
      input  rdy, stall, clear, instEnO, instEnT, instO, instT, PCO, PCT,
      output ifStall, occupancy, DecEnO, DecEnT, DecInstO, DecInstT, DecPCO, DecPCT
   );

   modport master (
      output rdy, stall, clear, instEnO, instEnT, instO, instT, PCO, PCT,
      input  ifStall, occupancy, DecEnO, DecEnT, DecInstO, DecInstT, DecPCO, DecPCT
   );
endinterface

// File: rtl/ring_ptr_adv.sv
// Circular pointer advance for a ring of DEPTH entries.
// Ports: ptr (current index 0..DEPTH-1), step (0..2), nxt (wrapped index).
// Wrapping compares against DEPTH-1 so non-power-of-two depths work.
module ring_ptr_adv #(
   parameter int DEPTH = 8
) (
   input  logic [$clog2(DEPTH)-1:0] ptr,
   input  logic [1:0]               step,
   output logic [$clog2(DEPTH)-1:0] nxt
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
   localparam logic [PW-1:0] PENULT = PW'(DEPTH - 2);

   always_comb begin
      nxt = ptr;
      case (step)
         2'd1:    nxt = (ptr == LAST) ? '0 : ptr + PW'(1);
         2'd2: begin
            if (ptr == LAST)        nxt = PW'(1);
            else if (ptr == PENULT) nxt = '0;
            else                    nxt = ptr + PW'(2);
         end
         default: nxt = ptr;
      endcase
   end
endmodule

// File: rtl/inst_queue_dual.sv
// Dual-issue instruction queue between fetch and decode.
// Ports: clk, rst (sync, active-high), bus (inst_queue_dual_if.slave).
// Takes up to two in-order instructions per cycle from fetch and hands up
// to two per cycle to decode on registered outputs. ifStall asks fetch to
// hold whenever fewer than two slots remain free.
module inst_queue_dual
   import front_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int INST_W = DEF_INST_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input logic               clk,
   input logic               rst,
   inst_queue_dual_if.slave  bus
);
   localparam int PW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [INST_W-1:0] insts [DEPTH];
   logic [ADDR_W-1:0] pcs   [DEPTH];

   logic [PW-1:0]    head, tail, head_p1, tail_p1, head_nxt, tail_nxt;
   logic [CNT_W-1:0] count;
   logic [1:0]       enq_num, deq_num;
   logic             go;

   assign go            = bus.rdy & ~rst & ~bus.clear;
   assign bus.ifStall   = count > CNT_W'(DEPTH - 2);
   assign bus.occupancy = count;

   // Both counts are taken from the registered count, so a freshly written
   // entry is never visible to dequeue in the same cycle.
   always_comb begin
      enq_num = 2'd0;
      deq_num = 2'd0;
      if (go & ~bus.ifStall & bus.instEnO)
         enq_num = bus.instEnT ? 2'd2 : 2'd1;
      if (go & ~bus.stall) begin
         if (count >= CNT_W'(2))      deq_num = 2'd2;
         else if (count == CNT_W'(1)) deq_num = 2'd1;
      end
   end

   ring_ptr_adv #(.DEPTH(DEPTH)) u_head_p1  (.ptr(head), .step(2'd1),   .nxt(head_p1));
   ring_ptr_adv #(.DEPTH(DEPTH)) u_head_adv (.ptr(head), .step(deq_num), .nxt(head_nxt));
   ring_ptr_adv #(.DEPTH(DEPTH)) u_tail_p1  (.ptr(tail), .step(2'd1),   .nxt(tail_p1));
   ring_ptr_adv #(.DEPTH(DEPTH)) u_tail_adv (.ptr(tail), .step(enq_num), .nxt(tail_nxt));

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (enq_num != 2'd0) begin
         insts[tail] <= bus.instO;
         pcs[tail]   <= bus.PCO;
      end
      if (enq_num == 2'd2) begin
         insts[tail_p1] <= bus.instT;
         pcs[tail_p1]   <= bus.PCT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         bus.DecEnO   <= DISABLE;
         bus.DecEnT   <= DISABLE;
         bus.DecInstO <= '0;
         bus.DecInstT <= '0;
         bus.DecPCO   <= '0;
         bus.DecPCT   <= '0;
      end else if (bus.clear) begin
         // Flush drops queue contents; last decode data is left in place.
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         bus.DecEnO <= DISABLE;
         bus.DecEnT <= DISABLE;
      end else if (bus.rdy) begin
         head  <= head_nxt;
         tail  <= tail_nxt;
         count <= count + CNT_W'(enq_num) - CNT_W'(deq_num);
         if (!bus.stall) begin
            bus.DecEnO <= (deq_num != 2'd0) ? VALID : INVALID;
            bus.DecEnT <= (deq_num == 2'd2) ? VALID : INVALID;
            if (deq_num != 2'd0) begin
               bus.DecInstO <= insts[head];
               bus.DecPCO   <= pcs[head];
            end
            if (deq_num == 2'd2) begin
               bus.DecInstT <= insts[head_p1];
               bus.DecPCT   <= pcs[head_p1];
            end
         end
      end
   end
endmodule

// File: tb/tb_inst_queue_dual.sv
// Directed bench for inst_queue_dual: a DEPTH=8 instance for the main
// sequence and a DEPTH=5 instance for pointer wrap-around.
module tb_inst_queue_dual;
   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   inst_queue_dual_if #(.DEPTH(8)) bus_a ();
   inst_queue_dual_if #(.DEPTH(5)) bus_b ();

   inst_queue_dual #(.DEPTH(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   inst_queue_dual #(.DEPTH(5)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input int n, input logic [31:0] pc);
      bus_a.instEnO = 1'b1;
      bus_a.instEnT = (n == 2);
      bus_a.PCO     = pc;
      bus_a.PCT     = pc + 32'd4;
      bus_a.instO   = ~pc;
      bus_a.instT   = ~(pc + 32'd4);
   endtask

   task automatic idle_a();
      bus_a.instEnO = 1'b0;
      bus_a.instEnT = 1'b0;
   endtask

   int          grp [8] = '{2, 1, 2, 2, 1, 2, 1, 1};
   int          gi, got;
   logic [31:0] push_pc, exp_pc;
   logic        st;

   initial begin
      rst = 1'b1;
      bus_a.rdy = 1'b1; bus_a.stall = 1'b0; bus_a.clear = 1'b0;
      bus_a.instEnO = 1'b0; bus_a.instEnT = 1'b0;
      bus_a.instO = '0; bus_a.instT = '0; bus_a.PCO = '0; bus_a.PCT = '0;
      bus_b.rdy = 1'b1; bus_b.stall = 1'b0; bus_b.clear = 1'b0;
      bus_b.instEnO = 1'b0; bus_b.instEnT = 1'b0;
      bus_b.instO = '0; bus_b.instT = '0; bus_b.PCO = '0; bus_b.PCT = '0;
      step(); step();
      rst = 1'b0;

      // reset state
      chk("rst_occ", 64'(bus_a.occupancy), 0);
      chk("rst_ifstall", 64'(bus_a.ifStall), 0);
      chk("rst_den0", 64'(bus_a.DecEnO), 0);
      chk("rst_den1", 64'(bus_a.DecEnT), 0);
      chk("rst_pc0", 64'(bus_a.DecPCO), 0);
      chk("rst_inst0", 64'(bus_a.DecInstO), 0);

      // two pair enqueues with decode stalled, then two pair dequeues
      bus_a.stall = 1'b1;
      push_a(2, 32'h0); step();
      push_a(2, 32'h8); step();
      chk("pair_occ4", 64'(bus_a.occupancy), 4);
      idle_a(); bus_a.stall = 1'b0; step();
      chk("pair1_den0", 64'(bus_a.DecEnO), 1);
      chk("pair1_den1", 64'(bus_a.DecEnT), 1);
      chk("pair1_pc0", 64'(bus_a.DecPCO), 64'h0);
      chk("pair1_pc1", 64'(bus_a.DecPCT), 64'h4);
      chk("pair1_inst0", 64'(bus_a.DecInstO), 64'hFFFF_FFFF);
      chk("pair1_inst1", 64'(bus_a.DecInstT), 64'hFFFF_FFFB);
      chk("pair1_occ", 64'(bus_a.occupancy), 2);
      step();
      chk("pair2_pc0", 64'(bus_a.DecPCO), 64'h8);
      chk("pair2_pc1", 64'(bus_a.DecPCT), 64'hC);
      chk("pair2_occ", 64'(bus_a.occupancy), 0);
      step();
      chk("empty_den0", 64'(bus_a.DecEnO), 0);
      chk("empty_den1", 64'(bus_a.DecEnT), 0);
      chk("empty_pc0_hold", 64'(bus_a.DecPCO), 64'h8);

      // fill to 7 under stall, blocked enqueue, then drain
      bus_a.stall = 1'b1;
      push_a(2, 32'h20); step();
      push_a(2, 32'h28); step();
      push_a(2, 32'h30); step();
      chk("fill_occ6", 64'(bus_a.occupancy), 6);
      chk("fill_ifstall6", 64'(bus_a.ifStall), 0);
      push_a(1, 32'h38); step();
      chk("fill_occ7", 64'(bus_a.occupancy), 7);
      chk("fill_ifstall7", 64'(bus_a.ifStall), 1);
      push_a(2, 32'h3C); step();
      chk("fill_drop_occ", 64'(bus_a.occupancy), 7);
      chk("fill_stall_den0", 64'(bus_a.DecEnO), 0);
      idle_a(); bus_a.stall = 1'b0; step();
      chk("drain1_pc0", 64'(bus_a.DecPCO), 64'h20);
      chk("drain1_pc1", 64'(bus_a.DecPCT), 64'h24);
      chk("drain1_occ", 64'(bus_a.occupancy), 5);
      chk("drain1_ifstall", 64'(bus_a.ifStall), 0);
      step();
      chk("drain2_pc0", 64'(bus_a.DecPCO), 64'h28);
      step();
      chk("drain3_pc1", 64'(bus_a.DecPCT), 64'h34);
      step();
      chk("drain4_den0", 64'(bus_a.DecEnO), 1);
      chk("drain4_den1", 64'(bus_a.DecEnT), 0);
      chk("drain4_pc0", 64'(bus_a.DecPCO), 64'h38);
      chk("drain4_pc1_hold", 64'(bus_a.DecPCT), 64'h34);
      chk("drain4_occ", 64'(bus_a.occupancy), 0);

      // single entry into empty queue: one cycle latency, slot 1 invalid
      push_a(1, 32'h10); step();
      chk("odd_occ1", 64'(bus_a.occupancy), 1);
      chk("odd_latency_den0", 64'(bus_a.DecEnO), 0);
      idle_a(); step();
      chk("odd_den0", 64'(bus_a.DecEnO), 1);
      chk("odd_den1", 64'(bus_a.DecEnT), 0);
      chk("odd_pc0", 64'(bus_a.DecPCO), 64'h10);
      chk("odd_occ0", 64'(bus_a.occupancy), 0);

      // flush with count=5 and a simultaneous enqueue
      bus_a.stall = 1'b1;
      push_a(2, 32'h40); step();
      push_a(2, 32'h48); step();
      push_a(1, 32'h50); step();
      chk("clr_pre_occ", 64'(bus_a.occupancy), 5);
      push_a(2, 32'h60); bus_a.clear = 1'b1; step();
      bus_a.clear = 1'b0; idle_a();
      chk("clr_occ", 64'(bus_a.occupancy), 0);
      chk("clr_den0", 64'(bus_a.DecEnO), 0);
      chk("clr_den1", 64'(bus_a.DecEnT), 0);
      chk("clr_ifstall", 64'(bus_a.ifStall), 0);
      chk("clr_pc0_hold", 64'(bus_a.DecPCO), 64'h10);
      bus_a.stall = 1'b0;
      push_a(1, 32'h100); step();
      idle_a(); step();
      chk("postclr_den0", 64'(bus_a.DecEnO), 1);
      chk("postclr_den1", 64'(bus_a.DecEnT), 0);
      chk("postclr_pc0", 64'(bus_a.DecPCO), 64'h100);
      chk("postclr_occ", 64'(bus_a.occupancy), 0);

      // rdy low freezes everything
      bus_a.stall = 1'b1;
      push_a(2, 32'h200); step();
      chk("rdy_pre_occ", 64'(bus_a.occupancy), 2);
      bus_a.rdy = 1'b0; bus_a.stall = 1'b0;
      push_a(2, 32'h300);
      step(); step(); step();
      chk("rdy_occ", 64'(bus_a.occupancy), 2);
      chk("rdy_den0", 64'(bus_a.DecEnO), 1);
      chk("rdy_pc0", 64'(bus_a.DecPCO), 64'h100);

      // lane 1 without lane 0 is ignored
      bus_a.rdy = 1'b1; bus_a.stall = 1'b1;
      bus_a.instEnO = 1'b0; bus_a.instEnT = 1'b1; bus_a.PCT = 32'h400;
      step();
      chk("t_only_occ", 64'(bus_a.occupancy), 2);
      idle_a(); bus_a.stall = 1'b0; step();
      chk("t_only_pc0", 64'(bus_a.DecPCO), 64'h200);
      chk("t_only_pc1", 64'(bus_a.DecPCT), 64'h204);
      chk("t_only_den1", 64'(bus_a.DecEnT), 1);
      step();
      chk("t_only_empty", 64'(bus_a.DecEnO), 0);

      // wrap-around on DEPTH=5: mixed groups, periodic decode stall
      gi = 0; got = 0; push_pc = 32'h1000; exp_pc = 32'h1000;
      for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
         st = ((cyc % 5) < 2);
         bus_b.stall = st;
         if (gi < 8 && !bus_b.ifStall) begin
            bus_b.instEnO = 1'b1;
            bus_b.instEnT = (grp[gi] == 2);
            bus_b.PCO = push_pc; bus_b.PCT = push_pc + 32'd4;
            bus_b.instO = ~push_pc; bus_b.instT = ~(push_pc + 32'd4);
            push_pc = push_pc + 32'(4 * grp[gi]);
            gi++;
         end else begin
            bus_b.instEnO = 1'b0;
            bus_b.instEnT = 1'b0;
         end
         step();
         if (bus_b.DecEnT) chk("wrap_en_order", 64'(bus_b.DecEnO), 1);
         if (!st && bus_b.DecEnO) begin
            chk("wrap_pc0", 64'(bus_b.DecPCO), 64'(exp_pc));
            exp_pc = exp_pc + 32'd4; got++;
            if (bus_b.DecEnT) begin
               chk("wrap_pc1", 64'(bus_b.DecPCT), 64'(exp_pc));
               exp_pc = exp_pc + 32'd4; got++;
            end
         end
      end
      bus_b.instEnO = 1'b0; bus_b.instEnT = 1'b0; bus_b.stall = 1'b0;
      chk("wrap_total", 64'(got), 12);
      chk("wrap_pushed", 64'(gi), 8);
      step();
      chk("wrap_occ", 64'(bus_b.occupancy), 0);
      chk("wrap_tail_empty", 64'(bus_b.DecEnO), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
